calc_pipe: RTL and testbench

//  Parametrised, pipelined successor to the vending-machine register-file/ALU calculator.
//  - Accepts one command per cycle over a valid/ready handshake.
//  - Register file and ALU are split into a 2-stage pipeline with saturating arithmetic.
//  - Flags overflow and pulses a response strobe.
//  - Exposes the designated "paid" register to the display/dispense logic.

---
 rtl/calc_pipe.sv | 192 +++++++++++++++++++
 tb/tb_calc_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_pipe.sv
// ----------------------------------------------------------------------------
// calc_pipe
// Two-stage pipelined register-file / saturating ALU calculator for the vending
// machine. One command per cycle is accepted over a valid/ready handshake.
// Stage 1 latches the command and its operands; stage 2 computes the result,
// writes it back and pulses rsp_valid. The register at PAID_REG is mirrored on
// paid for the display/dispense logic.
//
// Optional feature macro: CALC_BYPASS_EN
//   defined   : operands that hit the in-flight destination are forwarded from
//               the stage-2 ALU result; cmd_ready stays at 1.
//   undefined : such a hazard drops cmd_ready for one cycle instead.
//   Results are identical either way; only timing differs.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   cmd_valid  command present
//   cmd_ready  command accepted when cmd_valid & cmd_ready
//   op         opcode: ADD SUB ADDI LDI CLR CMP SHL NOP (0..7)
//   rw/ra/rb   destination / operand A / operand B register indices
//   imm        immediate, zero-extended to DATA_W
//   rsp_valid  one-cycle strobe, result of the retiring command
//   rsp_data   result of the retiring command
//   ovf        saturation occurred in the retiring command
//   paid       current contents of regs[PAID_REG]
// ----------------------------------------------------------------------------
module calc_pipe #(
    parameter int unsigned DATA_W   = 10,
    parameter int unsigned NREGS    = 16,
    parameter int unsigned IMM_W    = 4,
    parameter int unsigned PAID_REG = 4,
    localparam int unsigned AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        op,
    input  logic [AW-1:0]     rw,
    input  logic [AW-1:0]     ra,
    input  logic [AW-1:0]     rb,
    input  logic [IMM_W-1:0]  imm,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              ovf,
    output logic [DATA_W-1:0] paid
);

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpSub  = 3'd1,
        OpAddi = 3'd2,
        OpLdi  = 3'd3,
        OpClr  = 3'd4,
        OpCmp  = 3'd5,
        OpShl  = 3'd6,
        OpNop  = 3'd7
    } op_e;

    localparam logic [AW:0]   NREGS_W  = (AW + 1)'(NREGS);
    localparam logic [AW-1:0] PAID_IDX = AW'(PAID_REG);

    logic [DATA_W-1:0] regs [NREGS];

    // Stage-1 command registers
    logic              s1_valid;
    op_e               s1_op;
    logic [AW-1:0]     s1_rw;
    logic [IMM_W-1:0]  s1_imm;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;

    logic              accept;
    logic              s1_we;
    logic              haz_a;
    logic              haz_b;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] addend;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;

    // Indices beyond NREGS (non power-of-two sizes) read as 0 and never write.
    assign rd_a = ({1'b0, ra} < NREGS_W) ? regs[ra] : '0;
    assign rd_b = ({1'b0, rb} < NREGS_W) ? regs[rb] : '0;

    assign s1_we = s1_valid && (s1_op != OpNop) && ({1'b0, s1_rw} < NREGS_W);
    assign haz_a = s1_we && (ra == s1_rw);
    assign haz_b = s1_we && (rb == s1_rw);

`ifdef CALC_BYPASS_EN
    assign opa       = haz_a ? alu_res : rd_a;
    assign opb       = haz_b ? alu_res : rd_b;
    assign cmd_ready = 1'b1;
`else
    // Stall one cycle; the writeback lands on that edge so the retry reads it.
    assign opa       = rd_a;
    assign opb       = rd_b;
    assign cmd_ready = !(haz_a || haz_b);
`endif

    assign accept = cmd_valid && cmd_ready;

    // Stage-2 saturating ALU
    assign imm_ext = DATA_W'(s1_imm);
    assign addend  = (s1_op == OpAddi) ? imm_ext : s1_b;
    assign sum     = {1'b0, s1_a} + {1'b0, addend};

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (s1_op)
            OpAdd, OpAddi: begin
                if (sum[DATA_W]) begin
                    alu_res = '1;
                    alu_ovf = 1'b1;
                end else begin
                    alu_res = sum[DATA_W-1:0];
                end
            end
            OpSub: begin
                if (s1_a < s1_b) begin
                    alu_ovf = 1'b1;
                end else begin
                    alu_res = s1_a - s1_b;
                end
            end
            OpLdi: alu_res = imm_ext;
            OpClr: alu_res = '0;
            OpCmp: alu_res[0] = (s1_a >= s1_b);
            OpShl: begin
                if (s1_a[DATA_W-1]) begin
                    alu_res = '1;
                    alu_ovf = 1'b1;
                end else begin
                    alu_res = {s1_a[DATA_W-2:0], 1'b0};
                end
            end
            OpNop: alu_res = s1_a;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= OpNop;
            s1_rw     <= '0;
            s1_imm    <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            ovf       <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_op  <= op_e'(op);
                s1_rw  <= rw;
                s1_imm <= imm;
                s1_a   <= opa;
                s1_b   <= opb;
            end
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_data <= alu_res;
                ovf      <= alu_ovf;
            end else begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (s1_we) begin
            regs[s1_rw] <= alu_res;
        end
    end

    assign paid = regs[PAID_IDX];

endmodule

// File: tb/tb_calc_pipe.sv
// ----------------------------------------------------------------------------
// tb_calc_pipe
// Drives two calc_pipe instances with identical commands: the default build
// (DATA_W=10, NREGS=16, PAID_REG=4) and a narrow one (DATA_W=8, NREGS=8,
// PAID_REG=2). A behavioural model per instance computes each result at accept
// time and queues it; responses are popped and compared when rsp_valid pulses.
// ----------------------------------------------------------------------------
module tb_calc_pipe;

    localparam int W0 = 10;
    localparam int P0 = 4;
    localparam int W1 = 8;
    localparam int P1 = 2;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, ADDI = 3'd2, LDI = 3'd3;
    localparam logic [2:0] CLR = 3'd4, CMP = 3'd5, SHL = 3'd6, NOP = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid;
    logic [2:0] op;
    logic [3:0] rw, ra, rb, imm;

    logic          ready0, ready1;
    logic          rsp_valid0, rsp_valid1;
    logic [W0-1:0] rsp_data0, paid0;
    logic [W1-1:0] rsp_data1, paid1;
    logic          ovf0, ovf1;

    always #5 clk = ~clk;

    calc_pipe u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (ready0),
        .op        (op),
        .rw        (rw),
        .ra        (ra),
        .rb        (rb),
        .imm       (imm),
        .rsp_valid (rsp_valid0),
        .rsp_data  (rsp_data0),
        .ovf       (ovf0),
        .paid      (paid0)
    );

    calc_pipe #(
        .DATA_W   (W1),
        .NREGS    (8),
        .IMM_W    (4),
        .PAID_REG (P1)
    ) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (ready1),
        .op        (op),
        .rw        (rw[2:0]),
        .ra        (ra[2:0]),
        .rb        (rb[2:0]),
        .imm       (imm),
        .rsp_valid (rsp_valid1),
        .rsp_data  (rsp_data1),
        .ovf       (ovf1),
        .paid      (paid1)
    );

    typedef struct {
        int unsigned data;
        bit          ovf;
        int unsigned paid;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int unsigned m0[16];
    int unsigned m1[8];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic void alu(input int dw, input logic [2:0] o, input int unsigned a,
                                input int unsigned b, input int unsigned im,
                                output int unsigned r, output bit v);
        int unsigned mx;
        mx = (1 << dw) - 1;
        v  = 1'b0;
        r  = 0;
        case (o)
            ADD:  begin r = a + b;  if (r > mx) begin r = mx; v = 1'b1; end end
            SUB:  begin if (a < b) v = 1'b1; else r = a - b; end
            ADDI: begin r = a + im; if (r > mx) begin r = mx; v = 1'b1; end end
            LDI:  r = im;
            CLR:  r = 0;
            CMP:  r = (a >= b) ? 1 : 0;
            SHL:  begin r = a * 2;  if (r > mx) begin r = mx; v = 1'b1; end end
            default: r = a;
        endcase
    endfunction

    task automatic model_accept();
        int unsigned r;
        bit          v;
        alu(W0, op, m0[ra], m0[rb], imm, r, v);
        if (op != NOP) m0[rw] = r;
        q0.push_back('{r, v, m0[P0]});
        alu(W1, op, m1[ra[2:0]], m1[rb[2:0]], imm, r, v);
        if (op != NOP) m1[rw[2:0]] = r;
        q1.push_back('{r, v, m1[P1]});
    endtask

    task automatic model_clear();
        foreach (m0[i]) m0[i] = 0;
        foreach (m1[i]) m1[i] = 0;
        q0.delete();
        q1.delete();
    endtask

    // Present a command and hold it until accepted (bounded).
    task automatic issue(input logic [2:0] o, input int w, input int a, input int b,
                         input int im);
        bit done;
        done      = 1'b0;
        cmd_valid = 1'b1;
        op        = o;
        rw        = 4'(w);
        ra        = 4'(a);
        rb        = 4'(b);
        imm       = 4'(im);
        for (int i = 0; i < 6 && !done; i++) begin
            @(negedge clk);
            check("ready_match", ready1, ready0);
            if (ready0) begin
                model_accept();
                last_acc = cyc;
                done     = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        op        = NOP;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset with a command still in stage 1; its writeback must never land.
    task automatic reset_mid();
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_rsp_valid0", rsp_valid0, 0);
            check("rst_rsp_valid1", rsp_valid1, 0);
            check("rst_paid0", paid0, 0);
            check("rst_paid1", paid1, 0);
        end
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (rsp_valid0) begin
                if (q0.size() == 0) begin
                    check("rsp0_unexpected", 1, 0);
                end else begin
                    e = q0.pop_front();
                    check("rsp0_data", rsp_data0, e.data);
                    check("rsp0_ovf", ovf0, e.ovf);
                    check("rsp0_paid", paid0, e.paid);
                end
            end
            if (rsp_valid1) begin
                if (q1.size() == 0) begin
                    check("rsp1_unexpected", 1, 0);
                end else begin
                    e = q1.pop_front();
                    check("rsp1_data", rsp_data1, e.data);
                    check("rsp1_ovf", ovf1, e.ovf);
                    check("rsp1_paid", paid1, e.paid);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_acc;
        cmd_valid = 1'b0;
        op = NOP; rw = '0; ra = '0; rb = '0; imm = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("idle_ready0", ready0, 1);
        check("idle_ready1", ready1, 1);
        check("idle_rsp_valid0", rsp_valid0, 0);
        check("idle_rsp_data0", rsp_data0, 0);
        check("idle_paid0", paid0, 0);
        check("idle_paid1", paid1, 0);

        // 1: reset while a write to each paid register is in flight
        issue(LDI, 4, 0, 0, 7);
        reset_mid();
        issue(LDI, 2, 0, 0, 9);
        reset_mid();
        for (int i = 0; i < 8; i++) issue(NOP, 0, i, 0, 0);
        idle(3);

        // 2: basic chain
        issue(LDI, 1, 0, 0, 5);
        issue(LDI, 2, 0, 0, 3);
        issue(ADD, 4, 1, 2, 0);
        idle(3);
        check("chain_paid0", paid0, 8);
        check("chain_paid1", paid1, 3);

        // 3: saturation
        issue(LDI, 1, 0, 0, 15);
        repeat (7) issue(SHL, 1, 1, 0, 0);
        issue(LDI, 2, 0, 0, 3);
        issue(SUB, 4, 2, 1, 0);
        idle(3);
        check("sat_paid0", paid0, 0);

        // 4: back-to-back read-after-write on r4
        issue(CLR, 4, 0, 0, 0);
        issue(ADDI, 4, 4, 0, 5);
        first_acc = last_acc;
        repeat (3) issue(ADDI, 4, 4, 0, 5);
`ifdef CALC_BYPASS_EN
        check("hazard_span", last_acc - first_acc, 3);
`else
        check("hazard_span", last_acc - first_acc, 6);
`endif
        idle(3);
        check("hazard_paid0", paid0, 20);
        issue(ADDI, 2, 2, 0, 15);
        issue(ADD, 2, 2, 2, 0);
        idle(3);

        // 5: CMP and NOP
        issue(LDI, 1, 0, 0, 10);
        issue(LDI, 2, 0, 0, 10);
        issue(CMP, 3, 1, 2, 0);
        issue(LDI, 2, 0, 0, 11);
        issue(CMP, 3, 1, 2, 0);
        issue(NOP, 4, 3, 0, 0);
        for (int i = 0; i < 8; i++) issue(NOP, 0, i, 0, 0);
        idle(4);

        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
